mdv_ctrl: RTL and testbench
===========================

Name: mdv_ctrl

Overview:
- CPU-side microdrive controller sitting between the CPU register decode and the per-drive microdrive replay blocks.
- Implements the drive-select shift register and muxes gap, rx_ready and data from the selected drive.
- Captures bytes into a 2-entry receive FIFO and raises a gap interrupt.
- Drives the `sel` input of each microdrive replay instance and consumes its `gap`, `rx_ready` and `dout` outputs.

Parameters:
- NUM_DRIVES, 2, number of attached microdrive instances (1..8).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  one-clk strobe: write control byte
- int_clr  in  1  one-clk strobe: clear gap interrupt
- status_rd  in  1  one-clk strobe: status register read (clears overrun)
- data_rd  in  1  one-clk strobe: pop receive FIFO
- cpu_din  in  8  control byte: bit0 SEL_DI, bit1 SEL_CK, bit2 WR_EN, bit3 ERASE
- status  out  8  bit0 gap (live), bit1 rx_ready (FIFO non-empty), bit2 FIFO full, bit3 overrun, bit4 gap_irq, bits7:5 = 0
- data  out  8  FIFO head byte, 0x00 when empty
- gap_irq  out  1  sticky gap interrupt request
- mdv_sel  out  NUM_DRIVES  one-hot select to drives (bit0 = MDV1)
- mdv_wr_en  out  1  registered WR_EN
- mdv_erase  out  1  registered ERASE
- mdv_gap  in  NUM_DRIVES  per-drive gap
- mdv_rx_ready  in  NUM_DRIVES  per-drive rx_ready, level, high for many clk
- mdv_dout  in  8*NUM_DRIVES  per-drive data, drive i at [8i+7:8i]

Behaviour:
- Reset values: shift reg 0, mdv_sel 0, mdv_wr_en 0, mdv_erase 0, FIFO empty, overrun 0, gap_irq 0, status 0x01 (no drive, gap=1), data 0x00.
- Control register:
  - On ctrl_wr, latch cpu_din[3:0]; mdv_wr_en and mdv_erase follow one clk later.
  - Rising SEL_CK (previous latched 0, new 1) shifts: sel_sr <= {sel_sr[6:0], SEL_DI}.
- Selection:
  - mdv_sel[i] = sel_sr[i] only for the lowest set index below NUM_DRIVES; all other bits 0.
  - No bit set means no drive: gap_mux=1, rx_mux=0, dout_mux=0.
- Edge detection:
  - rx_prev samples rx_mux every clk.
  - Capture event = rx_mux & !rx_prev (one event per rx_ready pulse regardless of its length).
  - gap_prev is handled the same way; gap event = gap_mux & !gap_prev.
- Select change:
  - In the clk after mdv_sel changes, flush the FIFO and load rx_prev/gap_prev with the current mux values.
  - No capture or interrupt fires in that clk.
- FIFO:
  - 2 entries, write on capture event, read on data_rd.
  - data shows the head combinationally from the FIFO register.
  - Capture and pop in the same clk with 1 entry: count stays 1 and the head becomes the new byte.
  - Capture and pop with 2 entries: pop then push; count stays 2.
  - Pop when empty is ignored.
  - Capture when full with no pop: byte dropped, overrun set (see optional feature).
- Status read clears overrun one clk after status_rd; the returned value still shows 1. If a new overrun coincides, set wins.
- Gap interrupt: gap event sets gap_irq. int_clr clears it. Simultaneous set and clear: set wins.
- reset_n asserted mid-operation clears everything asynchronously; no partial FIFO state survives.

Optional Feature:
- MDV_CTRL_OVERRUN_EN defined: overrun flag implemented as above.
- Undefined: status bit3 is constant 0, no overrun register exists, overflowing bytes are still dropped silently.

Decomposition:
- Package mdv_pkg holds:
  - control bit positions CTRL_SEL_DI=0, CTRL_SEL_CK=1, CTRL_WR_EN=2, CTRL_ERASE=3
  - status bit positions ST_GAP=0, ST_RXRDY=1, ST_FULL=2, ST_OVR=3, ST_IRQ=4
  - RX_FIFO_DEPTH=2
- One sub-module, mdv_rx_fifo: 2-entry byte FIFO with push, pop, flush, full/empty/count.

Test Plan:
- Select MDV2: write ctrl 0x01, 0x03, 0x00, 0x02 -> sel_sr=0b10, mdv_sel=2'b10, status bit0 follows mdv_gap[1].
- Capture with held level: mdv_rx_ready[0] high for 40 clk with dout 0xA5, MDV1 selected -> exactly one FIFO entry; status=0x02|gap; data=0xA5; data_rd -> status bit1=0, data=0x00.
- Overrun (macro on): three rx pulses with 0x11, 0x22, 0x33, no reads -> data 0x11 then 0x22, byte 0x33 lost, status bit3=1; status_rd -> bit3=0 next clk. With the macro off, bit3 stays 0.
- Gap interrupt: mdv_gap rises 0->1 -> gap_irq=1 next clk; int_clr pulsed on the same clk as a second gap rising edge -> gap_irq stays 1.
- Select switch flush: FIFO holds 1 byte, shift to MDV2 while mdv_rx_ready[1] is already high -> FIFO empty, no capture, no irq.
- Asynchronous reset mid-run: assert reset_n=0 with FIFO full and gap_irq=1 -> same cycle status=0x01, mdv_sel=0, gap_irq=0.

Source files
------------

// File: rtl/mdv_pkg.sv
// Shared constants for the microdrive CPU-side controller: control/status bit positions
// and receive FIFO depth.
package mdv_pkg;

    localparam int CTRL_SEL_DI = 0;
    localparam int CTRL_SEL_CK = 1;
    localparam int CTRL_WR_EN  = 2;
    localparam int CTRL_ERASE  = 3;

    localparam int ST_GAP   = 0;
    localparam int ST_RXRDY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVR   = 3;
    localparam int ST_IRQ   = 4;

    localparam int unsigned RX_FIFO_DEPTH = 2;

    typedef logic [7:0] mdv_byte_t;

    function automatic mdv_byte_t pack_status(
        input logic gap,
        input logic rxrdy,
        input logic full,
        input logic ovr,
        input logic irq
    );
        mdv_byte_t s;
        s           = '0;
        s[ST_GAP]   = gap;
        s[ST_RXRDY] = rxrdy;
        s[ST_FULL]  = full;
        s[ST_OVR]   = ovr;
        s[ST_IRQ]   = irq;
        return s;
    endfunction

endpackage

// File: rtl/mdv_rx_fifo.sv
// Small byte FIFO for received microdrive data; push, pop and flush with full/empty/count.
// A push into a full FIFO is accepted only when a pop happens in the same clock.
module mdv_rx_fifo
    import mdv_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [7:0]                   wdata,
    output logic [7:0]                   rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mdv_ctrl.sv
// CPU-side microdrive controller: drive-select shift register, per-drive muxing, receive FIFO
// and gap interrupt. Define MDV_CTRL_OVERRUN_EN to implement the sticky overrun status flag.
module mdv_ctrl
    import mdv_pkg::*;
#(
    parameter int unsigned NUM_DRIVES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ctrl_wr,
    input  logic                    int_clr,
    input  logic                    status_rd,
    input  logic                    data_rd,
    input  logic [7:0]              cpu_din,
    output logic [7:0]              status,
    output logic [7:0]              data,
    output logic                    gap_irq,
    output logic [NUM_DRIVES-1:0]   mdv_sel,
    output logic                    mdv_wr_en,
    output logic                    mdv_erase,
    input  logic [NUM_DRIVES-1:0]   mdv_gap,
    input  logic [NUM_DRIVES-1:0]   mdv_rx_ready,
    input  logic [8*NUM_DRIVES-1:0] mdv_dout
);

    localparam int unsigned CW = $clog2(RX_FIFO_DEPTH + 1);

    logic [3:0]            ctrl_q;
    logic [7:0]            sel_sr_q;
    logic [NUM_DRIVES-1:0] sel_prev_q;
    logic                  rx_prev_q, gap_prev_q, gap_irq_q;
    logic                  sel_found, sel_chg;
    logic                  gap_mux, rx_mux;
    logic [7:0]            dout_mux;
    logic                  cap_ev, gap_ev;
    logic [7:0]            fifo_rdata;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  ovr;
    logic                  unused_bits;

    assign unused_bits = ^{cpu_din[7:4], sel_sr_q[7]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= '0;
            sel_sr_q <= '0;
        end else if (ctrl_wr) begin
            ctrl_q <= cpu_din[3:0];
            // Shift only on a rising SEL_CK between successive control writes.
            if (!ctrl_q[CTRL_SEL_CK] && cpu_din[CTRL_SEL_CK]) begin
                sel_sr_q <= {sel_sr_q[6:0], cpu_din[CTRL_SEL_DI]};
            end
        end
    end

    assign mdv_wr_en = ctrl_q[CTRL_WR_EN];
    assign mdv_erase = ctrl_q[CTRL_ERASE];

    // Lowest set shift-register bit within range wins; no bit set means no drive.
    always_comb begin
        mdv_sel   = '0;
        sel_found = 1'b0;
        gap_mux   = 1'b1;
        rx_mux    = 1'b0;
        dout_mux  = 8'h00;
        for (int i = 0; i < int'(NUM_DRIVES); i++) begin
            if (sel_sr_q[i] && !sel_found) begin
                sel_found  = 1'b1;
                mdv_sel[i] = 1'b1;
                gap_mux    = mdv_gap[i];
                rx_mux     = mdv_rx_ready[i];
                dout_mux   = mdv_dout[8*i +: 8];
            end
        end
    end

    assign sel_chg = (mdv_sel != sel_prev_q);
    assign cap_ev  = rx_mux & ~rx_prev_q & ~sel_chg;
    assign gap_ev  = gap_mux & ~gap_prev_q & ~sel_chg;

    // gap_prev resets high to match the no-drive gap level, avoiding a spurious interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_prev_q <= '0;
            rx_prev_q  <= 1'b0;
            gap_prev_q <= 1'b1;
            gap_irq_q  <= 1'b0;
        end else begin
            sel_prev_q <= mdv_sel;
            rx_prev_q  <= rx_mux;
            gap_prev_q <= gap_mux;
            if (gap_ev)       gap_irq_q <= 1'b1;
            else if (int_clr) gap_irq_q <= 1'b0;
        end
    end

    assign gap_irq = gap_irq_q;

    mdv_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cap_ev),
        .pop     (data_rd),
        .flush   (sel_chg),
        .wdata   (dout_mux),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef MDV_CTRL_OVERRUN_EN
    logic ovr_q;
    logic ovr_set;

    assign ovr_set = cap_ev & fifo_full & ~data_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ovr_q <= 1'b0;
        else if (ovr_set)   ovr_q <= 1'b1;
        else if (status_rd) ovr_q <= 1'b0;
    end

    assign ovr = ovr_q;
`else
    logic unused_status_rd;
    assign unused_status_rd = status_rd;
    assign ovr              = 1'b0;
`endif

    assign data   = fifo_empty ? 8'h00 : fifo_rdata;
    assign status = pack_status(gap_mux, fifo_count != '0, fifo_full, ovr, gap_irq_q);

endmodule

// File: tb/tb_mdv_ctrl.sv
// Scenario-driven bench for mdv_ctrl; received bytes are tracked in an expected-data queue.
module tb_mdv_ctrl;

    localparam int unsigned ND = 2;
`ifdef MDV_CTRL_OVERRUN_EN
    localparam logic [7:0] OVR_BIT = 8'h08;
`else
    localparam logic [7:0] OVR_BIT = 8'h00;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ctrl_wr, int_clr, status_rd, data_rd;
    logic [7:0]      cpu_din;
    logic [7:0]      status, data;
    logic            gap_irq;
    logic [ND-1:0]   mdv_sel;
    logic            mdv_wr_en, mdv_erase;
    logic [ND-1:0]   mdv_gap, mdv_rx_ready;
    logic [8*ND-1:0] mdv_dout;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    mdv_ctrl #(
        .NUM_DRIVES (ND)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctrl_wr      (ctrl_wr),
        .int_clr      (int_clr),
        .status_rd    (status_rd),
        .data_rd      (data_rd),
        .cpu_din      (cpu_din),
        .status       (status),
        .data         (data),
        .gap_irq      (gap_irq),
        .mdv_sel      (mdv_sel),
        .mdv_wr_en    (mdv_wr_en),
        .mdv_erase    (mdv_erase),
        .mdv_gap      (mdv_gap),
        .mdv_rx_ready (mdv_rx_ready),
        .mdv_dout     (mdv_dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        cpu_din = v;
        ctrl_wr = 1'b1;
        tick();
        ctrl_wr = 1'b0;
    endtask

    task automatic rx_pulse(input int drv, input logic [7:0] b);
        mdv_dout[8*drv +: 8] = b;
        mdv_rx_ready[drv]    = 1'b1;
        tick();
        tick();
        mdv_rx_ready[drv]    = 1'b0;
        tick();
    endtask

    task automatic rd_pop(input string name);
        logic [7:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        vectors++;
        if (data !== exp) begin
            miscompares++;
            $display("FAIL %s: data got %h want %h", name, data, exp);
        end
        data_rd = 1'b1;
        tick();
        data_rd = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (status !== 8'h01) begin
            miscompares++; $display("FAIL reset_status: got %h want %h", status, 8'h01);
        end
        vectors++;
        if ({data, mdv_sel, gap_irq, mdv_wr_en, mdv_erase} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: data %h sel %b irq %b we %b er %b want all 0",
                     data, mdv_sel, gap_irq, mdv_wr_en, mdv_erase);
        end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (status !== 8'h01) begin
            miscompares++; $display("FAIL post_reset_status: got %h want %h", status, 8'h01);
        end
    endtask

    task automatic test_select();
        wr_ctrl(8'h01);
        wr_ctrl(8'h03);
        vectors++;
        if (mdv_sel !== 2'b01) begin
            miscompares++; $display("FAIL sel_mdv1: got %b want %b", mdv_sel, 2'b01);
        end
        wr_ctrl(8'h00);
        wr_ctrl(8'h02);
        vectors++;
        if (mdv_sel !== 2'b10) begin
            miscompares++; $display("FAIL sel_mdv2: got %b want %b", mdv_sel, 2'b10);
        end
        tick();
        mdv_gap = 2'b01;
        tick();
        vectors++;
        if (status[0] !== 1'b0) begin
            miscompares++; $display("FAIL gap_follow_lo: got %b want 0", status[0]);
        end
        mdv_gap = 2'b10;
        tick();
        vectors++;
        if ({status[0], gap_irq} !== 2'b11) begin
            miscompares++; $display("FAIL gap_follow_hi: got %b want 11", {status[0], gap_irq});
        end
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        vectors++;
        if (gap_irq !== 1'b0) begin
            miscompares++; $display("FAIL irq_clear: got %b want 0", gap_irq);
        end
        mdv_gap = 2'b00;
        tick();
        wr_ctrl(8'h0E);
        vectors++;
        if ({mdv_wr_en, mdv_erase, mdv_sel} !== 4'b1110) begin
            miscompares++;
            $display("FAIL wr_erase_on: got %b want 1110", {mdv_wr_en, mdv_erase, mdv_sel});
        end
        wr_ctrl(8'h02);
        vectors++;
        if ({mdv_wr_en, mdv_erase} !== 2'b00) begin
            miscompares++; $display("FAIL wr_erase_off: got %b want 00", {mdv_wr_en, mdv_erase});
        end
    endtask

    task automatic test_capture();
        wr_ctrl(8'h01);
        wr_ctrl(8'h03);
        tick();
        tick();
        mdv_dout[7:0]   = 8'hA5;
        mdv_rx_ready[0] = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (40) tick();
        mdv_rx_ready[0] = 1'b0;
        tick();
        vectors++;
        if (status !== 8'h02) begin
            miscompares++; $display("FAIL capture_status: got %h want %h", status, 8'h02);
        end
        rd_pop("capture_data");
        vectors++;
        if ({status, data} !== 16'h0000) begin
            miscompares++; $display("FAIL capture_empty: status %h data %h want 00 00", status, data);
        end
    endtask

    task automatic test_overrun();
        rx_pulse(0, 8'h11); exp_q.push_back(8'h11);
        rx_pulse(0, 8'h22); exp_q.push_back(8'h22);
        rx_pulse(0, 8'h33);
        vectors++;
        if (status !== (8'h06 | OVR_BIT)) begin
            miscompares++; $display("FAIL ovr_set: got %h want %h", status, 8'h06 | OVR_BIT);
        end
        status_rd = 1'b1;
        #1;
        vectors++;
        if (status !== (8'h06 | OVR_BIT)) begin
            miscompares++; $display("FAIL ovr_read_val: got %h want %h", status, 8'h06 | OVR_BIT);
        end
        tick();
        status_rd = 1'b0;
        vectors++;
        if (status !== 8'h06) begin
            miscompares++; $display("FAIL ovr_cleared: got %h want %h", status, 8'h06);
        end
        rd_pop("ovr_first");
        rd_pop("ovr_second");
        vectors++;
        if (status !== 8'h00) begin
            miscompares++; $display("FAIL ovr_drained: got %h want %h", status, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        rx_pulse(0, 8'h44); exp_q.push_back(8'h44);
        exp = exp_q.pop_front();
        vectors++;
        if (data !== exp) begin
            miscompares++; $display("FAIL b2b_head1: got %h want %h", data, exp);
        end
        mdv_dout[7:0] = 8'h55; mdv_rx_ready[0] = 1'b1; data_rd = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        data_rd = 1'b0; mdv_rx_ready[0] = 1'b0;
        vectors++;
        if ({status, data} !== {8'h02, exp_q[0]}) begin
            miscompares++;
            $display("FAIL b2b_one: status %h data %h want 02 %h", status, data, exp_q[0]);
        end
        tick();
        rx_pulse(0, 8'h66); exp_q.push_back(8'h66);
        exp = exp_q.pop_front();
        vectors++;
        if (data !== exp) begin
            miscompares++; $display("FAIL b2b_head2: got %h want %h", data, exp);
        end
        mdv_dout[7:0] = 8'h77; mdv_rx_ready[0] = 1'b1; data_rd = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        data_rd = 1'b0; mdv_rx_ready[0] = 1'b0;
        vectors++;
        if (status !== 8'h06) begin
            miscompares++; $display("FAIL b2b_full: got %h want %h", status, 8'h06);
        end
        tick();
        rd_pop("b2b_pop66");
        rd_pop("b2b_pop77");
        vectors++;
        if (status !== 8'h00) begin
            miscompares++; $display("FAIL b2b_empty: got %h want %h", status, 8'h00);
        end
    endtask

    task automatic test_gap_irq();
        mdv_gap = 2'b01;
        tick();
        vectors++;
        if (gap_irq !== 1'b1) begin
            miscompares++; $display("FAIL irq_rise: got %b want 1", gap_irq);
        end
        mdv_gap = 2'b00;
        tick();
        vectors++;
        if (gap_irq !== 1'b1) begin
            miscompares++; $display("FAIL irq_sticky: got %b want 1", gap_irq);
        end
        mdv_gap = 2'b01; int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        vectors++;
        if (gap_irq !== 1'b1) begin
            miscompares++; $display("FAIL irq_set_wins: got %b want 1", gap_irq);
        end
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        vectors++;
        if (status !== 8'h01) begin
            miscompares++; $display("FAIL irq_cleared: got %h want %h", status, 8'h01);
        end
        mdv_gap = 2'b00;
        tick();
    endtask

    task automatic test_flush();
        rx_pulse(0, 8'h99); exp_q.push_back(8'h99);
        vectors++;
        if (status !== 8'h02) begin
            miscompares++; $display("FAIL flush_pre: got %h want %h", status, 8'h02);
        end
        mdv_dout[15:8] = 8'hBB; mdv_rx_ready[1] = 1'b1; mdv_gap = 2'b10;
        wr_ctrl(8'h00);
        wr_ctrl(8'h02);
        repeat (3) tick();
        exp_q.delete();
        vectors++;
        if ({status, data, gap_irq, mdv_sel} !== {8'h01, 8'h00, 1'b0, 2'b10}) begin
            miscompares++;
            $display("FAIL flush_post: status %h data %h irq %b sel %b want 01 00 0 10",
                     status, data, gap_irq, mdv_sel);
        end
        mdv_rx_ready[1] = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        rx_pulse(1, 8'hC1);
        rx_pulse(1, 8'hC2);
        vectors++;
        if (status !== 8'h07) begin
            miscompares++; $display("FAIL ar_full: got %h want %h", status, 8'h07);
        end
        mdv_gap = 2'b00;
        tick();
        mdv_gap = 2'b10;
        tick();
        vectors++;
        if (gap_irq !== 1'b1) begin
            miscompares++; $display("FAIL ar_irq: got %b want 1", gap_irq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++;
        if ({status, data, mdv_sel, gap_irq} !== {8'h01, 8'h00, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL ar_clear: status %h data %h sel %b irq %b want 01 00 00 0",
                     status, data, mdv_sel, gap_irq);
        end
        mdv_gap = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        vectors++;
        if ({status, mdv_sel} !== {8'h01, 2'b00}) begin
            miscompares++;
            $display("FAIL ar_release: status %h sel %b want 01 00", status, mdv_sel);
        end
    endtask

    initial begin
        reset_n = 1'b0; ctrl_wr = 1'b0; int_clr = 1'b0; status_rd = 1'b0; data_rd = 1'b0;
        cpu_din = 8'h00; mdv_gap = '0; mdv_rx_ready = '0; mdv_dout = '0;
        test_reset();
        test_select();
        test_capture();
        test_overrun();
        test_back_to_back();
        test_gap_irq();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
